// File: rtl/hrm_ang_dec_25b.sv
// Angle decoder: iterative vectoring CORDIC recovering theta and |v|*K
// from a signed Q1.23 {sin, cos} pair.
module hrm_ang_dec_25b #(
    parameter int ITER  = 24,
    parameter int GUARD = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_vld,
    output logic             o_rdy,
    input  logic [1:0][24:0] i_val,
    output logic             o_vld,
    input  logic             i_rdy,
    output logic [24:0]      o_theta,
    output logic [24:0]      o_mag,
    output logic             o_zero
);

    localparam int W  = 27 + GUARD;
    localparam int KW = 5;
    localparam logic signed [W-1:0] RND = W'((1 << GUARD) >> 1);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    state_t               state;
    logic signed [W-1:0]  x, y;
    logic        [24:0]   z;
    logic        [KW-1:0] k;
    logic                 zf;

    logic signed [W-1:0]  sin_ext, cos_ext;
    logic signed [W-1:0]  xs, ys, xr;
    logic        [24:0]   mag_sat;

    function automatic logic [24:0] atan_lut(input logic [KW-1:0] idx);
        logic [24:0] v;
        case (idx)
            5'd0:    v = 25'h0400000;
            5'd1:    v = 25'h025C80A;
            5'd2:    v = 25'h013F671;
            5'd3:    v = 25'h00A2224;
            5'd4:    v = 25'h005161B;
            5'd5:    v = 25'h0028BB0;
            5'd6:    v = 25'h00145EC;
            5'd7:    v = 25'h000A2F9;
            5'd8:    v = 25'h000517D;
            5'd9:    v = 25'h00028BE;
            5'd10:   v = 25'h000145F;
            5'd11:   v = 25'h0000A30;
            5'd12:   v = 25'h0000518;
            5'd13:   v = 25'h000028C;
            5'd14:   v = 25'h0000146;
            5'd15:   v = 25'h00000A3;
            5'd16:   v = 25'h0000051;
            5'd17:   v = 25'h0000029;
            5'd18:   v = 25'h0000014;
            5'd19:   v = 25'h000000A;
            5'd20:   v = 25'h0000005;
            5'd21:   v = 25'h0000003;
            5'd22:   v = 25'h0000001;
            5'd23:   v = 25'h0000001;
            default: v = 25'h0000000;
        endcase
        return v;
    endfunction

    // Inputs widened with 2 integer guard bits (gain headroom) and GUARD LSBs
    always_comb begin
        sin_ext = W'($signed(i_val[0])) <<< GUARD;
        cos_ext = W'($signed(i_val[1])) <<< GUARD;
    end

    assign xs = x >>> k;
    assign ys = y >>> k;
    assign xr = (x + RND) >>> GUARD;

    always_comb begin
        mag_sat = xr[24:0];
        if (xr[W-1])
            mag_sat = '0;
        else if (|xr[W-2:25])
            mag_sat = '1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            o_rdy   <= 1'b1;
            o_vld   <= 1'b0;
            o_theta <= '0;
            o_mag   <= '0;
            o_zero  <= 1'b0;
            x       <= '0;
            y       <= '0;
            z       <= '0;
            k       <= '0;
            zf      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (i_vld) begin
                        o_rdy <= 1'b0;
                        k     <= '0;
                        zf    <= (i_val == '0);
                        state <= S_ITER;
                        // Left half-plane: rotate by pi so CORDIC converges
                        if (i_val[1][24]) begin
                            x <= -cos_ext;
                            y <= -sin_ext;
                            z <= 25'h1000000;
                        end else begin
                            x <= cos_ext;
                            y <= sin_ext;
                            z <= '0;
                        end
                    end
                end
                S_ITER: begin
                    if (!y[W-1]) begin
                        x <= x + ys;
                        y <= y - xs;
                        z <= z + atan_lut(k);
                    end else begin
                        x <= x - ys;
                        y <= y + xs;
                        z <= z - atan_lut(k);
                    end
                    k <= k + 1'b1;
                    if (k == KW'(ITER - 1))
                        state <= S_DONE;
                end
                S_DONE: begin
                    if (!o_vld) begin
                        o_vld   <= 1'b1;
                        o_theta <= zf ? 25'h0 : z;
                        o_mag   <= mag_sat;
                        o_zero  <= zf;
                    end else if (i_rdy) begin
                        o_vld <= 1'b0;
                        o_rdy <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hrm_ang_dec_25b.sv
// Scoreboard bench for hrm_ang_dec_25b: directed angles, zero,
// saturation, backpressure, mid-run reset and a short random sweep.
module tb_hrm_ang_dec_25b;

    localparam int  ITER  = 24;
    localparam real KG    = 1.6467602581210656;
    localparam real TWO25 = 33554432.0;
    localparam real PI    = 3.14159265358979;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_vld = 1'b0;
    logic             i_rdy = 1'b1;
    logic [1:0][24:0] i_val = '0;
    logic             o_rdy, o_vld, o_zero;
    logic [24:0]      o_theta, o_mag;

    always #5 clk = ~clk;

    hrm_ang_dec_25b #(.ITER(ITER), .GUARD(3)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_vld  (i_vld),
        .o_rdy  (o_rdy),
        .i_val  (i_val),
        .o_vld  (o_vld),
        .i_rdy  (i_rdy),
        .o_theta(o_theta),
        .o_mag  (o_mag),
        .o_zero (o_zero)
    );

    typedef struct {
        string name;
        int    theta;
        int    tn;
        int    tp;
        real   mag;
        real   mtol;
        bit    zero;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input bit ok,
                       input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    function automatic real sv(input logic [24:0] v);
        return real'(int'($signed(v)));
    endfunction

    function automatic real mag_model(input logic [24:0] s, input logic [24:0] c);
        real m;
        m = KG * $sqrt(sv(s) * sv(s) + sv(c) * sv(c));
        if (m > 33554431.0) m = 33554431.0;
        return m;
    endfunction

    function automatic int theta_model(input logic [24:0] s, input logic [24:0] c);
        real t;
        int  r;
        t = $atan2(sv(s), sv(c)) / (2.0 * PI) * TWO25;
        if (t < 0.0) t = t + TWO25;
        r = int'(t);
        if (r >= 33554432) r = r - 33554432;
        return r;
    endfunction

    // Monitor: pop and compare on every completed output handshake
    always @(negedge clk) begin
        if (rst_n && o_vld && i_rdy) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 1'b0, o_theta, 0);
            end else begin
                exp_t e;
                int   d;
                real  dm;
                e = sb.pop_front();
                d = int'(o_theta) - e.theta;
                if (d >= 16777216) d = d - 33554432;
                if (d < -16777216) d = d + 33554432;
                chk({e.name, "_theta"}, (d >= -e.tn) && (d <= e.tp),
                    o_theta, e.theta);
                dm = real'(o_mag) - e.mag;
                if (dm < 0.0) dm = -dm;
                chk({e.name, "_mag"}, dm <= e.mtol, o_mag, longint'(e.mag));
                chk({e.name, "_zero"}, o_zero == e.zero, o_zero, e.zero);
            end
        end
    end

    task automatic wait_rdy(input string nm);
        int n = 0;
        while (!o_rdy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!o_rdy) chk({nm, "_rdy_timeout"}, 1'b0, o_rdy, 1);
    endtask

    task automatic send(input string nm, input logic [24:0] s, input logic [24:0] c,
                        input int th, input int tn, input int tp,
                        input bit zr, input real mtol);
        exp_t e;
        int   n;
        wait_rdy(nm);
        i_val[0] = s;
        i_val[1] = c;
        i_vld    = 1'b1;
        @(posedge clk); #1;
        i_vld    = 1'b0;
        i_val[0] = 25'h0AAAAAA;
        i_val[1] = 25'h1555555;
        e.name  = nm;
        e.theta = th;
        e.tn    = tn;
        e.tp    = tp;
        e.mag   = zr ? 0.0 : mag_model(s, c);
        e.mtol  = mtol;
        e.zero  = zr;
        sb.push_back(e);
        n = 0;
        while (!o_vld && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_latency"}, n == ITER + 1, n, ITER + 1);
    endtask

    initial begin
        logic [24:0] th_hold, mg_hold;
        int          n;

        #12;
        chk("rst_vld",   o_vld == 1'b0, o_vld, 0);
        chk("rst_theta", o_theta == '0, o_theta, 0);
        chk("rst_mag",   o_mag == '0, o_mag, 0);
        chk("rst_zero",  o_zero == 1'b0, o_zero, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_rdy", o_rdy == 1'b1, o_rdy, 1);

        send("t1_zero_deg", 25'h0000000, 25'h0800000, 32'h0000000, 16, 16, 0, 64.0);
        send("t2_90",       25'h0800000, 25'h0000000, 32'h0800000, 16, 16, 0, 64.0);
        send("t2_180",      25'h0000000, 25'h1800000, 32'h1000000, 16, 16, 0, 64.0);
        send("t2_270",      25'h1800000, 25'h0000000, 32'h1800000, 16, 16, 0, 64.0);
        send("t3_45",       25'h05A827A, 25'h05A827A, 32'h0400000, 16, 16, 0, 64.0);
        send("t3_neg_lsb",  25'h1FFFFFF, 25'h0800000, 32'h0000000, 16, 0, 0, 64.0);
        send("t3_30",       25'h0400000, 25'h06ED9EC, 32'h02AAAAB, 16, 16, 0, 64.0);
        send("t3_150",      25'h0400000, 25'h1912614, 32'h0D55555, 16, 16, 0, 64.0);
        send("t3_m30",      25'h1C00000, 25'h06ED9EC, 32'h1D55555, 16, 16, 0, 64.0);
        send("t4_zero",     25'h0000000, 25'h0000000, 32'h0000000, 0, 0, 1, 0.0);
        send("fs_neg_cos",  25'h0000000, 25'h1000000, 32'h1000000, 16, 16, 0, 64.0);
        send("fs_225_sat",  25'h1000000, 25'h1000000, 32'h1400000, 16, 16, 0, 0.0);

        // Backpressure: result must hold and new requests be refused
        wait_rdy("t5");
        i_rdy = 1'b0;
        send("t5_bp", 25'h0400000, 25'h06ED9EC, 32'h02AAAAB, 16, 16, 0, 64.0);
        th_hold = o_theta;
        mg_hold = o_mag;
        for (int i = 0; i < 10; i++) begin
            i_vld    = 1'b1;
            i_val[0] = 25'h0800000;
            i_val[1] = 25'h0000000;
            @(posedge clk); #1;
            chk("t5_theta_hold", o_theta == th_hold, o_theta, th_hold);
            chk("t5_mag_hold",   o_mag == mg_hold, o_mag, mg_hold);
            chk("t5_vld_hold",   o_vld == 1'b1, o_vld, 1);
            chk("t5_rdy_low",    o_rdy == 1'b0, o_rdy, 0);
        end
        i_vld = 1'b0;
        i_rdy = 1'b1;
        @(posedge clk); #1;
        chk("t5_rel_rdy", o_rdy == 1'b1, o_rdy, 1);
        chk("t5_rel_vld", o_vld == 1'b0, o_vld, 0);

        // Reset at k=10 aborts the job with no output
        wait_rdy("t6");
        i_val[0] = 25'h0800000;
        i_val[1] = 25'h0800000;
        i_vld    = 1'b1;
        @(posedge clk); #1;
        i_vld = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_vld",   o_vld == 1'b0, o_vld, 0);
        chk("t6_theta", o_theta == '0, o_theta, 0);
        chk("t6_mag",   o_mag == '0, o_mag, 0);
        chk("t6_zero",  o_zero == 1'b0, o_zero, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t6_rdy", o_rdy == 1'b1, o_rdy, 1);
        repeat (40) @(posedge clk);
        #1;
        send("t6_after", 25'h0400000, 25'h1912614, 32'h0D55555, 16, 16, 0, 64.0);

        // Random sweep against the atan2 model
        for (int i = 0; i < 200; i++) begin
            real         r, a;
            int          s, c;
            logic [24:0] sl, cl;
            a  = real'($urandom_range(0, 33554431)) / TWO25 * 2.0 * PI;
            r  = 0.25 + 1.65 * real'($urandom_range(0, 1000)) / 1000.0;
            s  = int'(r * $sin(a) * 8388608.0);
            c  = int'(r * $cos(a) * 8388608.0);
            sl = 25'(s);
            cl = 25'(c);
            send("t7_rand", sl, cl, theta_model(sl, cl), 16, 16, 0, 64.0);
        end

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("sb_drained", sb.size() == 0, sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
